// File: rtl/procyon_lib_pkg.sv
// rtl/procyon_lib_pkg.sv - shared procyon library constants
package procyon_lib_pkg;

  // Floor for any derived binary index width; a single-entry vector still needs one bit.
  localparam int PROCYON_MIN_IDX_WIDTH = 1;

endpackage

// File: rtl/procyon_onehot2binary.sv
// rtl/procyon_onehot2binary.sv - one-hot (or zero) vector to binary index
module procyon_onehot2binary #(
  parameter int WIDTH     = 8,
  parameter int IDX_WIDTH = (WIDTH == 1) ? 1 : $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     onehot,
  output logic [IDX_WIDTH-1:0] binary
);

  // OR-reduction of set positions; a zero vector maps to index 0.
  always_comb begin
    binary = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) binary = binary | IDX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/procyon_rr_encoder_pick.sv
// rtl/procyon_rr_encoder_pick.sv - masked/unmasked lowest-set-bit round-robin picker
module procyon_rr_encoder_pick #(
  parameter int WIDTH     = 8,
  parameter int IDX_WIDTH = 3
) (
  input  logic [WIDTH-1:0]     req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [WIDTH-1:0]     pick
);

  logic [WIDTH-1:0] masked;
  logic [WIDTH-1:0] src;

  // Requests at or above the pointer win; otherwise wrap to the full vector.
  always_comb begin
    masked = '0;
    for (int i = 0; i < WIDTH; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
    src  = (|masked) ? masked : req;
    pick = src & (~src + WIDTH'(1));
  end

endmodule

// File: rtl/procyon_rr_encoder.sv
// rtl/procyon_rr_encoder.sv - registered round-robin encoder; optional PROCYON_RR_ENCODER_LOCK_EN adds i_lock
module procyon_rr_encoder
  import procyon_lib_pkg::*;
#(
  parameter int OPTN_WIDTH      = 8,
  parameter int GRANT_IDX_WIDTH = (OPTN_WIDTH == 1) ? PROCYON_MIN_IDX_WIDTH : $clog2(OPTN_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [OPTN_WIDTH-1:0]      i_req,
`ifdef PROCYON_RR_ENCODER_LOCK_EN
  input  logic                       i_lock,
`endif
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [OPTN_WIDTH-1:0]      o_grant,
  output logic [GRANT_IDX_WIDTH-1:0] o_grant_idx,
  output logic                       o_busy
);

  logic                       load;
  logic                       lock_hold;
  logic [GRANT_IDX_WIDTH-1:0] ptr;
  logic [GRANT_IDX_WIDTH-1:0] eff_ptr;
  logic [GRANT_IDX_WIDTH-1:0] next_ptr;
  logic [GRANT_IDX_WIDTH-1:0] pick_idx;
  logic [GRANT_IDX_WIDTH:0]   idx_inc;
  logic [OPTN_WIDTH-1:0]      pick;

  assign load   = !o_valid || i_ready;
  assign o_busy = o_valid && !i_ready;

`ifdef PROCYON_RR_ENCODER_LOCK_EN
  assign lock_hold = o_valid && i_ready && i_lock;
`else
  assign lock_hold = 1'b0;
`endif

  // A locked acceptance re-centres priority on the current grant for this same pick.
  assign eff_ptr = lock_hold ? o_grant_idx : ptr;

  procyon_rr_encoder_pick #(
    .WIDTH     (OPTN_WIDTH),
    .IDX_WIDTH (GRANT_IDX_WIDTH)
  ) u_pick (
    .req  (i_req),
    .ptr  (eff_ptr),
    .pick (pick)
  );

  procyon_onehot2binary #(
    .WIDTH     (OPTN_WIDTH),
    .IDX_WIDTH (GRANT_IDX_WIDTH)
  ) u_onehot2binary (
    .onehot (pick),
    .binary (pick_idx)
  );

  assign idx_inc  = {1'b0, pick_idx} + (GRANT_IDX_WIDTH+1)'(1);
  assign next_ptr = (idx_inc == (GRANT_IDX_WIDTH+1)'(OPTN_WIDTH)) ? '0 : idx_inc[GRANT_IDX_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid     <= 1'b0;
      o_grant     <= '0;
      o_grant_idx <= '0;
      ptr         <= '0;
    end else if (load) begin
      o_valid     <= |i_req;
      o_grant     <= pick;
      o_grant_idx <= pick_idx;
      ptr         <= (|i_req) ? next_ptr : eff_ptr;
    end
  end

endmodule

// File: doc/procyon_rr_encoder.md
Name: procyon_rr_encoder

Overview:
- Registered round-robin priority encoder: picks one requester from an N-bit request vector.
- Presents the pick as both one-hot and binary index behind a valid/ready output stage.
- Successor to the plain one-hot-to-binary converter: adds fairness state, multi-hot input tolerance and handshaked output.
- Used by issue/dispatch and LSU arbitration wherever several sources compete for one port.

Parameters:
- OPTN_WIDTH, 8, number of requesters (>=1)
- GRANT_IDX_WIDTH, OPTN_WIDTH==1 ? 1 : $clog2(OPTN_WIDTH), derived binary index width (not to be overridden)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_req  input  OPTN_WIDTH  request vector, any number of bits set
- i_ready  input  1  downstream accepts current output this cycle
- o_valid  output  1  output holds a grant
- o_grant  output  OPTN_WIDTH  registered one-hot grant
- o_grant_idx  output  GRANT_IDX_WIDTH  registered binary index of o_grant
- o_busy  output  1  o_valid && !i_ready (stall indication to requesters)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: o_valid=0, o_grant='0, o_grant_idx='0, priority pointer=0. Reset asserted mid-transfer drops the held grant unconditionally next edge.
- Load condition: load = !o_valid || i_ready. When load=0, o_valid/o_grant/o_grant_idx hold stable, pointer holds, i_req is ignored.
- Pick when load=1:
  - Masked request = i_req bits at positions >= pointer. If nonzero, grant its lowest set bit; otherwise grant the lowest set bit of unmasked i_req (wrap).
  - Output registers update next edge: o_valid=|i_req, o_grant=pick, o_grant_idx=binary(pick).
  - If i_req=0: o_valid=0, o_grant='0, o_grant_idx='0, pointer unchanged.
- Pointer update on a nonzero pick: pointer = idx+1, wrapping to 0 when idx=OPTN_WIDTH-1; arithmetic in GRANT_IDX_WIDTH+1 bits before compare.
- Latency: request to o_valid = 1 cycle. Back-to-back grants every cycle while i_ready=1.
- Requester protocol: a requester sees o_grant bit set with o_valid && i_ready as acceptance and must deassert or advance that cycle. A still-set request is eligible again only after the others, per pointer.
- Invariants: o_grant is one-hot or zero; o_grant_idx always consistent with o_grant; OPTN_WIDTH=1 degenerates to a registered valid with idx 0.

Optional Feature:
- PROCYON_RR_ENCODER_LOCK_EN
- Defined: adds input i_lock (1 bit). On an accepted transfer (o_valid && i_ready) with i_lock=1, the pointer is set to the current o_grant_idx rather than idx+1, so the same requester keeps top priority (multi-beat bursts).
- Not defined: port absent, pointer always advances as above.

Decomposition:
- Shared library package procyon_lib_pkg: no new typedefs; GRANT_IDX_WIDTH computed locally.
- Sub-module procyon_rr_encoder_pick: combinational masked/unmasked lowest-set-bit picker producing the one-hot pick.
- Binary conversion instantiates existing library procyon_onehot2binary.
- The registered stage and pointer live in the top.

Test Plan:
- Reset then i_req=8'b1010_0100, i_ready=1 -> next cycle o_valid=1, o_grant=8'b0000_0100, idx=2; then idx=5, then idx=7, then wrap to idx=2.
- i_req=8'hFF held, i_ready=1 for 10 cycles -> idx sequence 0,1,…,7,0,1 (fairness/wrap).
- Grant idx=3 valid, i_ready=0 for 4 cycles while i_req changes to 8'h01 -> outputs hold idx=3, o_busy=1; on i_ready=1 next grant idx=0.
- i_req=0 with i_ready=1 -> o_valid=0, o_grant=0, pointer unchanged; then i_req=8'h80 -> idx=7.
- rst asserted while o_valid=1 and i_ready=0 -> next edge o_valid=0, pointer=0; with i_req=8'h81 first grant is idx=0.
- LOCK_EN: i_req=8'h0C, i_lock=1, i_ready=1 -> idx stays 2 every cycle; i_lock=0 -> next idx=3.
